// File: rtl/mem_pkg.sv
// Shared load/store types: access-size encoding and the buffered entry layout.
package mem_pkg;

    localparam int MDB_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_FULL = 2'b11
    } size_e;

    typedef struct packed {
        logic [MDB_DATA_W-1:0] data;
        logic                  misalign;
    } mdb_entry_t;

endpackage

// File: rtl/mem_load_formatter.sv
// Combinational byte-lane extract + sign/zero extend + misalign detect; zero latency, no handshake.
module load_formatter
    import mem_pkg::*;
#(
    parameter  int DATA_W = MDB_DATA_W,
    localparam int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] i_data,
    input  size_e             i_size,
    input  logic              i_signed,
    input  logic [OFF_W-1:0]  i_offset,
    output logic [DATA_W-1:0] o_data,
    output logic              o_misalign
);

    localparam int IDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_shift;
    logic [IDX_W-1:0]  w_msb;
    logic [OFF_W-1:0]  w_mask;
    logic              w_ext;

    always_comb begin
        w_shift = i_data >> {i_offset, 3'b000};
        case (i_size)
            SZ_BYTE: begin w_msb = IDX_W'(7);        w_mask = OFF_W'(0); end
            SZ_HALF: begin w_msb = IDX_W'(15);       w_mask = OFF_W'(1); end
            SZ_WORD: begin w_msb = IDX_W'(31);       w_mask = OFF_W'(3); end
            default: begin w_msb = IDX_W'(DATA_W-1); w_mask = '1;        end
        endcase
        // Full-width access has nothing to extend, so the signed flag is moot.
        w_ext = i_signed && (i_size != SZ_FULL) && w_shift[w_msb];
        o_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_data[i] = (i <= int'(w_msb)) ? w_shift[i] : w_ext;
        end
        o_misalign = |(i_offset & w_mask);
    end

endmodule

// File: rtl/mem_data_buffer.sv
// DEPTH-entry load-data FIFO, 1-cycle latency (MDB_BYPASS_EN: same-cycle pass-through when empty);
// in_ready drops only on full and never depends on out_ready; flush empties the queue.
module mem_data_buffer
    import mem_pkg::*;
#(
    parameter  int DATA_W = MDB_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int OFF_W  = $clog2(DATA_W/8),
    localparam int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [OFF_W-1:0]  in_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              misalign;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] w_fmt_data;
    logic              w_fmt_mis;
    logic              w_empty;
    logic              w_show_in;
    logic              w_byp;
    logic              w_push;
    logic              w_pop;

    load_formatter #(.DATA_W(DATA_W)) u_fmt (
        .i_data     (in_data),
        .i_size     (size_e'(in_size)),
        .i_signed   (in_signed),
        .i_offset   (in_offset),
        .o_data     (w_fmt_data),
        .o_misalign (w_fmt_mis)
    );

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != CNT_W'(DEPTH));

`ifdef MDB_BYPASS_EN
    assign w_show_in = w_empty && in_valid && !flush;
    assign w_byp     = w_show_in && out_ready;
`else
    assign w_show_in = 1'b0;
    assign w_byp     = 1'b0;
`endif

    assign out_valid    = !w_empty || w_show_in;
    assign out_data     = w_show_in ? w_fmt_data : (w_empty ? '0 : r_mem[r_rd_ptr].data);
    assign out_misalign = w_show_in ? w_fmt_mis  : (w_empty ? 1'b0 : r_mem[r_rd_ptr].misalign);
    assign count        = r_count;

    // A bypassed beat is consumed directly and must not also land in storage.
    assign w_push = in_valid && in_ready && !w_byp;
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= '{data: w_fmt_data, misalign: w_fmt_mis};
        end
    end

endmodule
